hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage SAD datapath. Detects load-use hazards in ID and inserts a one-cycle bubble, flushes IF/ID and ID/EX when a branch in EX resolves taken, and holds the front of the pipeline while a multi-cycle EX operation (the SAD absolute-difference/accumulate unit) completes. It sits beside the forwarding unit. It owns the pipeline register write-enables, flushes and PC write-enable.

---
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage SAD datapath.
// Handles three cases:
//   - load-use stalls, which insert a one-cycle bubble;
//   - taken-branch flushes of IF/ID and ID/EX;
//   - front-end holds while a multi-cycle SAD op occupies EX.
// It drives the PC and pipeline register enables and flushes.
//
// Optional build macro: HAZARD_PERF_CNT_EN adds saturating performance counters.
//
// Parameters:
//   MC_LAT          cycles a multi-cycle op occupies EX (2..16)
// Ports:
//   Clk, Rst        clock, synchronous active-high reset
//   IF_ID_Rs/Rt     source fields of the instruction in ID
//   ID_UsesRt       ID instruction reads Rt
//   ID_EX_MemRead   EX instruction is a load
//   ID_EX_Rt        load destination in EX
//   EX_BranchTaken  branch in EX resolved taken
//   EX_MC_Start     multi-cycle op entered EX this cycle
//   PCWrite, IF_ID_Write, ID_EX_Write               load enables
//   IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble         flush/bubble controls
//   Stall           front end held this cycle
//   StallCycles, FlushCount (HAZARD_PERF_CNT_EN only) event counters
module hazard_ctrl #(
  parameter int unsigned MC_LAT = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] IF_ID_Rs,
  input  logic [4:0] IF_ID_Rt,
  input  logic       ID_UsesRt,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rt,
  input  logic       EX_BranchTaken,
  input  logic       EX_MC_Start,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       EX_MEM_Bubble,
  output logic       Stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);

  typedef enum logic [1:0] {RUN, LU_STALL, MC_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;

  // Load in EX writes a register the ID instruction is about to read.
  assign lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
              ((ID_EX_Rt == IF_ID_Rs) || (ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and combinational pipeline controls.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    Stall         = 1'b0;

    if (Rst) begin
      // Hold everything and push NOPs through while in reset.
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      EX_MEM_Bubble = 1'b1;
      state_nxt     = RUN;
      cnt_nxt       = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (EX_BranchTaken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (EX_MC_Start) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            Stall         = 1'b1;
            cnt_nxt       = MC_LOAD;
            state_nxt     = MC_BUSY;
          end else if (lu) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            Stall       = 1'b1;
            state_nxt   = LU_STALL;
          end
        end
        // Bubble sits in EX; nothing in EX can raise a hazard this cycle.
        LU_STALL: state_nxt = RUN;
        MC_BUSY: begin
          if (cnt != '0) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            Stall         = 1'b1;
            cnt_nxt       = cnt - CNT_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall-cycle and flush counters.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (Stall && (StallCycles != '1)) StallCycles <= StallCycles + 32'd1;
      if (IF_ID_Flush && (FlushCount != '1)) FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule
